truth_table_sequencer: RTL

Self-checking stimulus controller for the 3-input gate-level combinational circuit (`circuit3_2`, Z = (A·B) ⊕ ¬(B·C)). On a start request it steps A, B, C through all eight input combinations. Each vector is held for a programmable settle time, and Z is sampled at the end of that window. The eight samples are assembled into a truth-table byte and compared against an expected mask. The block replaces hand-timed stimulus with a synthesizable, reusable exhaustive-check sequencer.

---
 rtl/truth_seq_pkg.sv | 8 +
 rtl/truth_seq_settle_timer.sv | 19 +
 rtl/truth_table_sequencer.sv | 62 ++++++
 3 files changed

// File: rtl/truth_seq_pkg.sv
// truth_seq_pkg: shared types and sizes for the truth-table sequencer
package truth_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NUM_VECTORS = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;
  localparam logic [7:0] GOLDEN_MASK = 8'hB7;
endpackage

// File: rtl/truth_seq_settle_timer.sv
// truth_seq_settle_timer: counts settle cycles per vector, expire on the last one
module truth_seq_settle_timer
  import truth_seq_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [CNT_W-1:0] cnt;
  assign expire = cnt == CNT_W'(SETTLE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= expire ? '0 : cnt + 1'b1;
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: drives all 8 {a,b,c} vectors, captures z and checks it against a golden table
module truth_table_sequencer
  import truth_seq_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter logic [7:0] EXPECTED = GOLDEN_MASK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [7:0] fail_mask,
  output logic       pass
);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [7:0] table_nx;
  logic expire, cap, last, accept;
  truth_seq_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(state == IDLE), .en(state == RUN), .expire(expire)
  );
  assign accept = state == IDLE && start;
  assign cap = state == RUN && expire;
  assign last = cap && idx == IDX_W'(NUM_VECTORS - 1);
  assign {a, b, c} = state == RUN ? idx : '0;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    table_nx = table_out;
    table_nx[idx] = z;
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // verdict is computed from the table as it completes so it is valid during DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      table_out <= '0;
      fail_mask <= '0;
      pass <= 1'b0;
    end else if (accept) begin
      idx <= '0;
      table_out <= '0;
      fail_mask <= '0;
      pass <= 1'b0;
    end else if (cap) begin
      idx <= idx + 1'b1;
      table_out <= table_nx;
      if (last) begin
        fail_mask <= table_nx ^ EXPECTED;
        pass <= ~|(table_nx ^ EXPECTED);
      end
    end
endmodule
